// File: rtl/periodic_frame_tx_pkg.sv
// Shared definitions for the periodic UART frame transmitter: serialiser
// state encoding, UART character geometry and the default bit divider.
package periodic_frame_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   // One start bit, eight data bits, one stop bit.
   localparam int unsigned UART_FRAME_BITS = 10;
   localparam int unsigned UART_DATA_BITS  = UART_FRAME_BITS - 2;

   // 12 MHz hwclk at 115200 baud.
   localparam int unsigned SYS_CLK_HZ       = 12_000_000;
   localparam int unsigned UART_BAUD        = 115_200;
   localparam int unsigned DEFAULT_BAUD_DIV = SYS_CLK_HZ / UART_BAUD;

endpackage

// File: rtl/periodic_frame_tx_uart_tx_byte.sv
// 8N1 byte serialiser. A start request seen in IDLE, or in the last cycle of
// a stop bit, loads tx_byte so consecutive bytes follow with no idle gap.
module uart_tx_byte
   import periodic_frame_tx_pkg::*;
#(
   parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
   input  logic       hwclk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] tx_byte,
   output logic       txd,
   output logic       busy,
   output logic       done
);

   localparam int unsigned TW = $clog2(BAUD_DIV);
   localparam int unsigned BW = $clog2(UART_DATA_BITS);

   tx_state_t      state_q, state_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic [BW-1:0]  bit_q, bit_d;
   logic [7:0]     shift_q, shift_d;
   logic           txd_q, txd_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           bit_end;

   assign bit_end = (timer_q == TW'(BAUD_DIV - 1));

   // State and registered line outputs.
   always_ff @(posedge hwclk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      timer_d = '0;
      bit_d   = bit_q;
      shift_d = shift_q;
      txd_d   = txd_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      if (state_q != ST_IDLE) begin
         timer_d = bit_end ? '0 : timer_q + TW'(1);
      end

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_START;
               shift_d = tx_byte;
               txd_d   = 1'b0;
               busy_d  = 1'b1;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               bit_d   = '0;
               txd_d   = shift_q[0];
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (bit_q == BW'(UART_DATA_BITS - 1)) begin
                  state_d = ST_STOP;
                  txd_d   = 1'b1;
               end else begin
                  bit_d   = bit_q + BW'(1);
                  shift_d = {1'b0, shift_q[7:1]};
                  txd_d   = shift_q[1];
               end
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               done_d = 1'b1;
               if (start) begin
                  state_d = ST_START;
                  shift_d = tx_byte;
                  txd_d   = 1'b0;
               end else begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign txd  = txd_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: rtl/periodic_frame_tx.sv
// Periodic / triggered UART frame transmitter: latches the payload at launch,
// sequences payload bytes plus an optional XOR checksum through the serialiser.
module periodic_frame_tx
   import periodic_frame_tx_pkg::*;
#(
   parameter int unsigned NBYTES   = 9,
   parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV,
   parameter int unsigned PERIOD   = 12_000_000,
   parameter int unsigned CSUM_EN  = 1
) (
   input  logic                hwclk,
   input  logic                rst,
   input  logic [8*NBYTES-1:0] payload,
   input  logic                trig,
   input  logic                auto_en,
   output logic                txd,
   output logic                busy,
   output logic                done,
   output logic                led
);

   localparam int unsigned TOTAL = NBYTES + ((CSUM_EN != 0) ? 1 : 0);
   localparam int unsigned IW    = $clog2(NBYTES + 2);
   localparam int unsigned PW    = $clog2(PERIOD);

   logic [PW-1:0]       pcnt_q;
   logic [IW-1:0]       idx_q;
   logic [8*NBYTES-1:0] frame_q;
   logic [7:0]          csum_q;
   logic                pend_q;
   logic                led_q;

   logic                tick_c;
   logic                req_c;
   logic                launch_c;
   logic                start_c;
   logic [7:0]          csum_in;
   logic [7:0]          first_byte;
   logic [7:0]          next_byte;
   logic [7:0]          tx_byte;
   logic                ser_txd;
   logic                ser_busy;
   logic                ser_done;

   // A frame is finished in the cycle the serialiser drops busy; that cycle
   // still blocks launches so a deferred request starts one cycle later.
   assign tick_c     = auto_en && (pcnt_q == PW'(PERIOD - 1));
   assign req_c      = !rst && (trig || tick_c);
   assign launch_c   = !rst && !ser_busy && !ser_done && (req_c || pend_q);
   assign first_byte = payload[8*NBYTES-1 -: 8];

   // idx_q counts bytes already handed to the serialiser.
   assign start_c = launch_c || (ser_busy && (idx_q < IW'(TOTAL)));
   assign tx_byte = launch_c ? first_byte : next_byte;

   always_comb begin
      csum_in = '0;
      for (int k = 0; k < int'(NBYTES); k++) begin
         csum_in = csum_in ^ payload[8*k +: 8];
      end
   end

   always_comb begin
      next_byte = csum_q;
      for (int k = 0; k < int'(NBYTES); k++) begin
         if (idx_q == IW'(k)) begin
            next_byte = frame_q[8*(int'(NBYTES)-k)-1 -: 8];
         end
      end
   end

   // Period counter, launch bookkeeping and payload latch.
   always_ff @(posedge hwclk) begin
      if (rst) begin
         pcnt_q  <= '0;
         idx_q   <= '0;
         frame_q <= '0;
         csum_q  <= '0;
         pend_q  <= 1'b0;
         led_q   <= 1'b0;
      end else begin
         if (!auto_en || tick_c) begin
            pcnt_q <= '0;
         end else begin
            pcnt_q <= pcnt_q + PW'(1);
         end

         if (launch_c) begin
            frame_q <= payload;
            csum_q  <= csum_in;
            idx_q   <= IW'(1);
            led_q   <= ~led_q;
            pend_q  <= 1'b0;
         end else begin
            if (req_c) begin
               pend_q <= 1'b1;
            end
            if (ser_done && ser_busy) begin
               idx_q <= idx_q + IW'(1);
            end
         end
      end
   end

   uart_tx_byte #(
      .BAUD_DIV (BAUD_DIV)
   ) u_tx_byte (
      .hwclk   (hwclk),
      .rst     (rst),
      .start   (start_c),
      .tx_byte (tx_byte),
      .txd     (ser_txd),
      .busy    (ser_busy),
      .done    (ser_done)
   );

   assign txd  = ser_txd;
   assign busy = ser_busy;
   assign done = ser_done && !ser_busy;
   assign led  = led_q;

endmodule

// File: tb/tb_periodic_frame_tx.sv
// Bench for periodic_frame_tx: per-cycle comparison against a launch-time
// reference model, plus directed frame decode and count checks.
module tb_periodic_frame_tx;

   localparam int NB    = 3;
   localparam int B     = 4;
   localparam int CS    = 1;
   localparam int PER   = 200;
   localparam int TOTAL = NB + CS;
   localparam int L     = 10 * B * TOTAL;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, trig, auto_en;
   logic [8*NB-1:0] payload;
   logic            txd, busy, done, led;

   logic            trig2, auto_en2;
   logic [7:0]      payload2;
   logic            txd2, busy2, done2, led2;

   periodic_frame_tx #(
      .NBYTES (NB), .BAUD_DIV (B), .PERIOD (PER), .CSUM_EN (CS)
   ) dut (
      .hwclk (clk), .rst (rst), .payload (payload), .trig (trig),
      .auto_en (auto_en), .txd (txd), .busy (busy), .done (done), .led (led)
   );

   periodic_frame_tx #(
      .NBYTES (1), .BAUD_DIV (B), .PERIOD (PER), .CSUM_EN (0)
   ) dut2 (
      .hwclk (clk), .rst (rst), .payload (payload2), .trig (trig2),
      .auto_en (auto_en2), .txd (txd2), .busy (busy2), .done (done2), .led (led2)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a frame launched in cycle n owns cycles n+1..n+L and
   // reports done in n+L+1; launches only happen outside that window.
   int  cyc     = 0;
   int  m_start = 0;
   bit  m_act   = 0;
   bit  m_pend  = 0;
   bit  m_led   = 0;
   int  m_pcnt  = 0;
   bit  m_bits[10*TOTAL];

   int  seg_busy, seg_done, seg_led, seg_done2;
   logic led_prev = 1'b0;
   logic q1[$];
   logic q2[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_launch(input logic [8*NB-1:0] p);
      logic [7:0] b;
      logic [7:0] cs;
      int pos;
      cs  = 8'h00;
      pos = 0;
      for (int k = 0; k < TOTAL; k++) begin
         if (k < NB) begin
            b  = p[8*(NB-k)-1 -: 8];
            cs = cs ^ b;
         end else begin
            b = cs;
         end
         m_bits[pos] = 1'b0;
         pos = pos + 1;
         for (int i = 0; i < 8; i++) begin
            m_bits[pos] = b[i];
            pos = pos + 1;
         end
         m_bits[pos] = 1'b1;
         pos = pos + 1;
      end
   endtask

   // One clock: sample at negedge, compare, advance model, return after posedge.
   task automatic step();
      bit e_busy, e_txd, e_done, idle, tick, req;
      @(negedge clk);
      e_busy = m_act && (cyc >= m_start + 1) && (cyc <= m_start + L);
      e_txd  = e_busy ? m_bits[(cyc - m_start - 1) / B] : 1'b1;
      e_done = m_act && (cyc == m_start + L + 1);
      check_eq("txd",  32'(txd),  32'(e_txd));
      check_eq("busy", 32'(busy), 32'(e_busy));
      check_eq("done", 32'(done), 32'(e_done));
      check_eq("led",  32'(led),  32'(m_led));

      seg_busy  += int'(busy);
      seg_done  += int'(done);
      seg_done2 += int'(done2);
      if (led !== led_prev) seg_led++;
      led_prev = led;
      if (busy)  q1.push_back(txd);
      if (busy2) q2.push_back(txd2);

      if (rst) begin
         m_act  = 0;
         m_pend = 0;
         m_led  = 0;
         m_pcnt = 0;
      end else begin
         idle = !(m_act && (cyc <= m_start + L + 1));
         tick = auto_en && (m_pcnt == PER - 1);
         req  = trig || tick;
         if (idle && (req || m_pend)) begin
            model_launch(payload);
            m_act   = 1;
            m_start = cyc;
            m_pend  = 0;
            m_led   = ~m_led;
         end else if (req) begin
            m_pend = 1;
         end
         m_pcnt = auto_en ? ((m_pcnt == PER - 1) ? 0 : m_pcnt + 1) : 0;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse_trig();
      trig = 1'b1;
      step();
      trig = 1'b0;
   endtask

   task automatic seg_clear();
      seg_busy  = 0;
      seg_done  = 0;
      seg_led   = 0;
      seg_done2 = 0;
      q1.delete();
      q2.delete();
   endtask

   initial begin
      logic [7:0] exp027 [4];
      logic       exp031 [10];
      logic [7:0] dec;

      exp027 = '{8'h31, 8'h32, 8'h33, 8'h30};
      exp031 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

      rst = 1'b1; trig = 1'b0; auto_en = 1'b0; payload = '0;
      trig2 = 1'b0; auto_en2 = 1'b0; payload2 = 8'hA5;
      run(3);
      rst = 1'b0;
      run(2);

      // Single frame; payload changes right after the launch cycle.
      seg_clear();
      payload = 24'h313233;
      pulse_trig();
      payload = 24'hA5C3FF;
      run(170);
      check_eq("t027_busy_cycles", 32'(seg_busy), 32'(160));
      check_eq("t027_done_pulses", 32'(seg_done), 32'(1));
      check_eq("t027_led_toggles", 32'(seg_led), 32'(1));
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 8; i++) dec[i] = q1[(10*k + 1 + i)*B + B/2];
         check_eq("t027_byte", 32'(dec), 32'(exp027[k]));
      end

      // Two extra triggers during a frame collapse to one pending frame.
      seg_clear();
      payload = 24'h0F1E2D;
      pulse_trig();
      run(9);
      payload = 24'h112233;
      pulse_trig();
      run(39);
      pulse_trig();
      run(300);
      check_eq("t028_led_toggles", 32'(seg_led), 32'(2));
      check_eq("t028_done_pulses", 32'(seg_done), 32'(2));
      check_eq("t028_busy_cycles", 32'(seg_busy), 32'(320));

      // Reset during data bit 3 of byte 1 aborts with no done.
      seg_clear();
      payload = 24'hC0FFEE;
      pulse_trig();
      run(57);
      rst = 1'b1;
      step();
      rst = 1'b0;
      run(10);
      check_eq("t030_abort_done", 32'(seg_done), 32'(0));
      pulse_trig();
      run(170);
      check_eq("t030_clean_done", 32'(seg_done), 32'(1));

      // Auto launches with terminal counts landing inside frames.
      seg_clear();
      auto_en = 1'b1;
      run(100);
      pulse_trig();
      for (int i = 0; i < 899; i++) begin
         payload = 24'($urandom);
         step();
      end
      auto_en = 1'b0;
      run(200);
      check_eq("t029_launches", 32'(seg_led), 32'(6));
      check_eq("t029_done_pulses", 32'(seg_done), 32'(6));

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         trig    = ($urandom_range(0, 99) < 3);
         payload = 24'($urandom);
         if ($urandom_range(0, 299) == 0) auto_en = ~auto_en;
         rst     = ($urandom_range(0, 999) == 0);
         step();
      end
      trig = 1'b0; auto_en = 1'b0; rst = 1'b0;
      run(200);

      // Single byte, no checksum.
      seg_clear();
      trig2 = 1'b1;
      step();
      trig2 = 1'b0;
      run(50);
      check_eq("t031_busy_cycles", 32'(q2.size()), 32'(40));
      check_eq("t031_done_pulses", 32'(seg_done2), 32'(1));
      for (int j = 0; j < 10; j++) begin
         check_eq("t031_bit", 32'(q2[j*B + B/2]), 32'(exp031[j]));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
